// File: rtl/demux_pkg.sv
// Shared widths and state/channel encodings for the 2-way demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 32;
  localparam int unsigned CNT_WIDTH   = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry synchronous FIFO with occupancy tracked as an EMPTY/ONE/FULL state machine.
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int unsigned Width = DEMUX_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [Width-1:0] head_o
);

  fifo_state_e      state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [2];
  logic             push_en, pop_en;

  // A push while FULL is dropped here as a second guard; the top never issues one.
  assign push_en = push_i && (state_q != FULL);
  assign pop_en  = pop_i && (state_q != EMPTY);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ push_en;
    rd_ptr_d = rd_ptr_q ^ pop_en;
    case (state_q)
      EMPTY: if (push_en) state_d = ONE;
      ONE: begin
        if (push_en && !pop_en)      state_d = FULL;
        else if (pop_en && !push_en) state_d = EMPTY;
      end
      FULL:    if (pop_en) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_en) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = (state_q == FULL);
  assign valid_o = (state_q != EMPTY);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/demux_2way.sv
// Registered 1-to-2 demux with a 2-entry buffer per output channel.
// Optional per-channel accepted-word counters are enabled by defining DEMUX_COUNT_EN.
module demux_2way
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     in_data_i,
  input  logic                 in_sel_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [WIDTH-1:0]     out0_data_o,
  output logic                 out0_valid_o,
  input  logic                 out0_ready_i,
  output logic [WIDTH-1:0]     out1_data_o,
  output logic                 out1_valid_o,
  input  logic                 out1_ready_i
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt0_o,
  output logic [CNT_WIDTH-1:0] cnt1_o
`endif
);

  ch_e  sel;
  logic full0, full1;
  logic push0, push1;
  logic pop0, pop1;
  logic xfer_in;

  assign sel = ch_e'(in_sel_i);

  // Ready depends only on registered occupancy and the select, never on sink ready.
  assign in_ready_o = (sel == CH1) ? !full1 : !full0;
  assign xfer_in    = in_valid_i && in_ready_o;
  assign push0      = xfer_in && (sel == CH0);
  assign push1      = xfer_in && (sel == CH1);
  assign pop0       = out0_valid_o && out0_ready_i;
  assign pop1       = out1_valid_o && out1_ready_i;

  demux_fifo2 #(
    .Width (WIDTH)
  ) u_fifo0 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push0),
    .data_i  (in_data_i),
    .pop_i   (pop0),
    .full_o  (full0),
    .valid_o (out0_valid_o),
    .head_o  (out0_data_o)
  );

  demux_fifo2 #(
    .Width (WIDTH)
  ) u_fifo1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push1),
    .data_i  (in_data_i),
    .pop_i   (pop1),
    .full_o  (full1),
    .valid_o (out1_valid_o),
    .head_o  (out1_data_o)
  );

`ifdef DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  // Counters wrap naturally at 2^CNT_WIDTH.
  always_comb begin
    cnt0_d = cnt0_q + {{(CNT_WIDTH-1){1'b0}}, push0};
    cnt1_d = cnt1_q + {{(CNT_WIDTH-1){1'b0}}, push1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0_o = cnt0_q;
  assign cnt1_o = cnt1_q;
`else
  // No counters in this build; routing logic above is unaffected.
`endif

endmodule

// File: tb/tb_demux_2way.sv
// Randomized bench for demux_2way against a queue-based reference of the two channels.
module tb_demux_2way;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_cnt0 = 0;
  int          m_cnt1 = 0;

  demux_2way u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_data_i    (in_data),
    .in_sel_i     (in_sel),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out0_data_o  (out0_data),
    .out0_valid_o (out0_valid),
    .out0_ready_i (out0_ready),
    .out1_data_o  (out1_data),
    .out1_valid_o (out1_valid),
    .out1_ready_i (out1_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt0_o       (cnt0),
    .cnt1_o       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare DUT outputs against the reference queues (called between edges).
  task automatic check_outputs(input string tag);
    check_eq({tag, " v0"}, {31'd0, out0_valid}, {31'd0, q0.size() != 0});
    check_eq({tag, " v1"}, {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    if (q0.size() != 0) check_eq({tag, " d0"}, out0_data, q0[0]);
    if (q1.size() != 0) check_eq({tag, " d1"}, out1_data, q1[0]);
`ifdef DEMUX_COUNT_EN
    check_eq({tag, " cnt0"}, {16'd0, cnt0}, m_cnt0 & 32'hFFFF);
    check_eq({tag, " cnt1"}, {16'd0, cnt1}, m_cnt1 & 32'hFFFF);
`endif
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic cycle(input string tag, input logic v, input logic s, input logic [31:0] d,
                       input logic r0, input logic r1);
    bit exp_rdy, do_push, do_pop0, do_pop1;
    check_outputs(tag);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_rdy = s ? (q1.size() < 2) : (q0.size() < 2);
    check_eq({tag, " rdy"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    do_push = v && exp_rdy;
    do_pop0 = r0 && (q0.size() != 0);
    do_pop1 = r1 && (q1.size() != 0);
    @(posedge clk);
    if (do_pop0) void'(q0.pop_front());
    if (do_pop1) void'(q1.pop_front());
    if (do_push) begin
      if (s) begin q1.push_back(d); m_cnt1++; end
      else   begin q0.push_back(d); m_cnt0++; end
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic r0, input logic r1);
    cycle(tag, 1'b0, 1'b0, 32'hDEAD_BEEF, r0, r1);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(negedge clk);
    // Reset values while still in reset.
    check_eq("rst d0", out0_data, 32'h0);
    check_eq("rst d1", out1_data, 32'h0);
    check_eq("rst rdy", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word to channel 0.
    cycle("t1 push", 1'b1, 1'b0, 32'h0000F320, 1'b1, 1'b0);
    check_eq("t1 v0", {31'd0, out0_valid}, 32'd1);
    check_eq("t1 d0", out0_data, 32'h0000F320);
    check_eq("t1 v1", {31'd0, out1_valid}, 32'd0);
    idle("t1 drain", 1'b1, 1'b0);

    // Fill channel 1, then observe backpressure on sel=1 only.
    cycle("t2 p1", 1'b1, 1'b1, 32'h00008001, 1'b0, 1'b0);
    cycle("t2 p2", 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    cycle("t2 blk1", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    check_eq("t2 rdy1", {31'd0, in_ready}, 32'd0);
    cycle("t2 rdy0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("t2 rdy0b", {31'd0, in_ready}, 32'd1);

    // Channel 1 stays full while channel 0 streams back-to-back.
    cycle("t3 a", 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0);
    cycle("t3 b", 1'b1, 1'b0, 32'h22222222, 1'b1, 1'b0);
    cycle("t3 c", 1'b1, 1'b0, 32'h33333333, 1'b1, 1'b0);
    check_eq("t3 d1 held", out1_data, 32'h00008001);
    idle("t3 drain", 1'b1, 1'b0);

    // Release channel 1: 8001 then FFFFFFFF.
    cycle("t2 rel1", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    check_eq("t2 second", out1_data, 32'hFFFFFFFF);
    idle("t2 rel2", 1'b0, 1'b1);

    // Push and pop in the same cycle while holding one word.
    cycle("t4 a", 1'b1, 1'b0, 32'hA0A0A0A0, 1'b0, 1'b0);
    cycle("t4 pp", 1'b1, 1'b0, 32'hB0B0B0B0, 1'b1, 1'b0);
    check_eq("t4 head", out0_data, 32'hB0B0B0B0);
    cycle("t4 one", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("t4 notfull", {31'd0, in_ready}, 32'd1);
    idle("t4 drain", 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    // Both channels full, then asynchronous reset between edges.
    idle("t5 flush", 1'b1, 1'b1);
    idle("t5 flush", 1'b1, 1'b1);
    cycle("t5 f0", 1'b1, 1'b0, 32'hC0000001, 1'b0, 1'b0);
    cycle("t5 f1", 1'b1, 1'b0, 32'hC0000002, 1'b0, 1'b0);
    cycle("t5 f2", 1'b1, 1'b1, 32'hC1000001, 1'b0, 1'b0);
    cycle("t5 f3", 1'b1, 1'b1, 32'hC1000002, 1'b0, 1'b0);
    check_eq("t5 full0", {31'd0, out0_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5 rst v0", {31'd0, out0_valid}, 32'd0);
    check_eq("t5 rst v1", {31'd0, out1_valid}, 32'd0);
    check_eq("t5 rst d0", out0_data, 32'h0);
    check_eq("t5 rst rdy", {31'd0, in_ready}, 32'd1);
    q0.delete();
    q1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle("t5 post", 1'b1, 1'b1);

`ifdef DEMUX_COUNT_EN
    // 65536 transfers to channel 0 wrap its counter back to zero.
    cycle("t6 c1", 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      in_data = i;
      @(posedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t6 cnt0 wrap", {16'd0, cnt0}, 32'd0);
    check_eq("t6 cnt1", {16'd0, cnt1}, 32'd1);
    check_eq("t6 last", out0_data, 32'd65535);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
